// File: rtl/present_key_schedule_if.sv
// Bus between a PRESENT-80 round-key consumer and present_key_schedule.
// Handshake: load (with key_in) starts a schedule; while valid=1 the
// consumer reads round_key/round_idx and pulses next to advance by one
// round. next is only honoured while valid=1. done reports that the last
// key was consumed and stays high until the next load. state_dbg mirrors
// the internal FSM state for observation only.
interface present_key_schedule_if;
  logic        load;
  logic [79:0] key_in;
  logic        next;
  logic [63:0] round_key;
  logic [5:0]  round_idx;
  logic        valid;
  logic        done;
  logic [1:0]  state_dbg;

  modport master (
    output load, key_in, next,
    input  round_key, round_idx, valid, done, state_dbg
  );

  modport slave (
    input  load, key_in, next,
    output round_key, round_idx, valid, done, state_dbg
  );
endinterface

// File: rtl/present_key_schedule.sv
// PRESENT-80 key schedule. Holds the 80-bit key register K and issues
// round keys K_1..K_LAST_ROUND, one per accepted next request.
// Optional feature macro: PRESENT_KS_ZEROIZE_EN -- when defined, K is
// cleared on entry to DONE and while idling, so no key material lingers.
module present_key_schedule #(
  parameter int LAST_ROUND = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  present_key_schedule_if.slave  ks
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [5:0] LAST_IDX = 6'(LAST_ROUND);

  state_e      state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [5:0]  idx_q, idx_d;
  logic [79:0] key_upd;

  // PRESENT 4-bit S-box applied to the top nibble of the rotated key.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // One key-schedule round: rotate left 61, S-box top nibble, XOR the
  // current (pre-increment) round counter into bits 19:15.
  always_comb begin
    key_upd          = {key_q[18:0], key_q[79:19]};
    key_upd[79:76]   = sbox(key_upd[79:76]);
    key_upd[19:15]   = key_upd[19:15] ^ idx_q[4:0];
  end

  // Next-state logic: load always wins; next only advances in ACTIVE.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    if (ks.load) begin
      key_d   = ks.key_in;
      idx_d   = 6'd1;
      state_d = ST_ACTIVE;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (ks.next) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
              idx_d   = 6'd0;
`ifdef PRESENT_KS_ZEROIZE_EN
              key_d   = 80'd0;
`endif
            end else begin
              key_d = key_upd;
              idx_d = idx_q + 6'd1;
            end
          end
        end
        ST_IDLE: begin
`ifdef PRESENT_KS_ZEROIZE_EN
          key_d = 80'd0;
`endif
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State, key and round-counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= 80'd0;
      idx_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  assign ks.round_key = key_q[79:16];
  assign ks.round_idx = idx_q;
  assign ks.valid     = (state_q == ST_ACTIVE);
  assign ks.done      = (state_q == ST_DONE);
  assign ks.state_dbg = state_q;

endmodule

// File: tb/tb_present_key_schedule.sv
// Self-checking bench for present_key_schedule: directed scenarios plus
// randomized load/next traffic compared against a round-key table model.
module tb_present_key_schedule;

  localparam int LAST = 32;

  logic clk;
  logic rst_n;
  present_key_schedule_if bus ();

  present_key_schedule #(.LAST_ROUND(LAST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: full table of round keys computed at load time.
  logic [3:0]  sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [79:0] exp_tab [0:LAST];
  int          m_mode;   // 0 idle, 1 active, 2 done
  int          m_idx;

  task automatic gen_table(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    exp_tab[0] = 80'd0;
    exp_tab[1] = k;
    for (int i = 1; i < LAST; i++) begin
      k = (k << 61) | (k >> 19);
      k[79:76] = sbox_tab[k[79:76]];
      k = k ^ (80'(i) << 15);
      exp_tab[i+1] = k;
    end
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] e_key;
    e_key = 64'd0;
    if (m_mode == 1) e_key = exp_tab[m_idx][79:16];
`ifndef PRESENT_KS_ZEROIZE_EN
    if (m_mode == 2) e_key = exp_tab[LAST][79:16];
`endif
    check({tag, ".round_key"}, 80'(bus.round_key), 80'(e_key));
    check({tag, ".round_idx"}, 80'(bus.round_idx), 80'(m_idx));
    check({tag, ".valid"},     80'(bus.valid),     80'(m_mode == 1));
    check({tag, ".done"},      80'(bus.done),      80'(m_mode == 2));
  endtask

  // Driver: called at a falling edge; applies inputs across one rising
  // edge, updates the model, then checks at the following falling edge.
  task automatic step(input logic ld, input logic [79:0] k, input logic nx, input string tag);
    bus.load   = ld;
    bus.key_in = k;
    bus.next   = nx;
    @(posedge clk);
    if (ld) begin
      gen_table(k);
      m_mode = 1;
      m_idx  = 1;
    end else if (m_mode == 1 && nx) begin
      if (m_idx == LAST) begin
        m_mode = 2;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
    @(negedge clk);
    bus.load = 1'b0;
    bus.next = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    logic [79:0] rk;
    logic        ld, nx;
    rst_n      = 1'b0;
    bus.load   = 1'b0;
    bus.key_in = 80'd0;
    bus.next   = 1'b0;
    m_mode     = 0;
    m_idx      = 0;
    gen_table(80'd0);
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("post_reset");

    // Zero key: first two round keys against published constants.
    step(1'b1, 80'd0, 1'b0, "load_zero");
    check("zero_k1", 80'(bus.round_key), 80'd0);
    step(1'b0, 80'd0, 1'b1, "zero_next1");
    check("zero_k2", 80'(bus.round_key), 80'(64'hC000_0000_0000_0000));

    // All-ones key.
    step(1'b1, {80{1'b1}}, 1'b0, "load_ones");
    check("ones_k1", 80'(bus.round_key), 80'(64'hFFFF_FFFF_FFFF_FFFF));
    step(1'b0, 80'd0, 1'b1, "ones_next1");
    check("ones_k2", 80'(bus.round_key), 80'(64'h2FFF_FFFF_FFFF_FFFF));

    // Full schedule to DONE on zero key, with a hold cycle mid-way.
    step(1'b1, 80'd0, 1'b0, "full_load");
    for (int i = 0; i < LAST - 1; i++) begin
      step(1'b0, 80'd0, 1'b1, "full_next");
      if (i == 10) repeat (3) step(1'b0, 80'd0, 1'b0, "full_hold");
    end
    check("full_idx_last", 80'(bus.round_idx), 80'(LAST));
    step(1'b0, 80'd0, 1'b1, "full_finish");
    check("full_done", 80'(bus.done), 80'd1);
    // next held in DONE is ignored.
    for (int i = 0; i < 10; i++) step(1'b0, 80'd0, 1'b1, "done_next_ignored");

    // Load and next together at round 5 acts as load only.
    step(1'b1, {80{1'b1}}, 1'b0, "r5_load");
    repeat (4) step(1'b0, 80'd0, 1'b1, "r5_next");
    check("r5_idx", 80'(bus.round_idx), 80'd5);
    step(1'b1, 80'd0, 1'b1, "r5_load_next");
    check("r5_restart_key", 80'(bus.round_key), 80'd0);

    // Asynchronous reset at round 10, between edges.
    step(1'b1, 80'h1234_5678_9ABC_DEF0_1357, 1'b0, "r10_load");
    repeat (9) step(1'b0, 80'd0, 1'b1, "r10_next");
    #2 rst_n = 1'b0;
    #1;
    m_mode = 0;
    m_idx  = 0;
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    // next held in IDLE is ignored until a load.
    for (int i = 0; i < 10; i++) step(1'b0, 80'd0, 1'b1, "idle_next_ignored");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 49) == 0);
      nx = ($urandom_range(0, 3) != 0);
      rk = {$urandom, $urandom, 16'($urandom)};
      step(ld, rk, nx, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/present_key_schedule.md
PRESENT_KEY_SCHEDULE -- requirements
Module: present_key_schedule

Interface
REQ-001 SHALL have parameter: LAST_ROUND, default 32, index of final round key issued (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: load  input  1  start; captures key_in.
REQ-005 SHALL have port: key_in  input  80  PRESENT-80 user key, bit 79 MSB.
REQ-006 SHALL have port: next  input  1  consumer request to advance to the next round key.
REQ-007 SHALL have port: round_key  output  64  current round key K_i, driven to addRoundKey ahead of sLayer/pLayer.
REQ-008 SHALL have port: round_idx  output  6  index i of round_key (1..LAST_ROUND); 0 when idle.
REQ-009 SHALL have port: valid  output  1  round_key/round_idx meaningful.
REQ-010 SHALL have port: done  output  1  last key consumed; held until next load.

Function
REQ-011 SHALL hold an 80-bit key register K; round_key SHALL equal K[79:16] combinationally.
REQ-012 SHALL implement states IDLE, ACTIVE, DONE; valid=1 only in ACTIVE, done=1 only in DONE.
REQ-013 load=1 at an edge in any state SHALL set K<=key_in, round_idx<=1, state<=ACTIVE; outputs visible the following cycle (latency 1).
REQ-014 next=1 in ACTIVE with round_idx<LAST_ROUND SHALL apply one update and increment round_idx.
REQ-015 Update order, all in one cycle: rotate K left 61 (K<={K[18:0],K[79:19]}); K[79:76]<=S(K[79:76]); K[19:15]<=K[19:15] XOR round_idx[4:0] (pre-increment value).
REQ-016 S-box S(0..F) SHALL be C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-017 next=1 in ACTIVE with round_idx==LAST_ROUND SHALL enter DONE; no key update; round_idx<=0.
REQ-018 next in IDLE or DONE SHALL be ignored.
REQ-019 load and next asserted together SHALL act as load only.
REQ-020 load in ACTIVE SHALL restart from round 1 with the new key, discarding progress.
REQ-021 In ACTIVE with next=0, K, round_idx and outputs SHALL hold indefinitely.
REQ-022 round_idx SHALL never exceed LAST_ROUND nor wrap.

Reset
REQ-023 rst_n=0 SHALL immediately, without clock, force state=IDLE, K=0, round_idx=0, valid=0, done=0, round_key=0.
REQ-024 Reset asserted mid-operation SHALL abandon the schedule; operation SHALL resume only on a subsequent load.
REQ-025 Release of rst_n SHALL be synchronised to clk externally; block SHALL take no action on the release edge beyond IDLE.

Configuration
REQ-026 Macro PRESENT_KS_ZEROIZE_EN defined: entering DONE, and load deasserted with state IDLE after reset, SHALL clear K to 0, so round_key reads 0 in DONE.
REQ-027 Macro PRESENT_KS_ZEROIZE_EN undefined: K SHALL retain its final value in DONE, round_key showing K_LAST_ROUND; all other behaviour identical.

Verification
REQ-028 Reset, load key_in=80'h0 -> next cycle valid=1, round_idx=1, round_key=64'h0; one next -> round_idx=2, round_key=64'hC000_0000_0000_0000.
REQ-029 load key_in=80'hFFFF_FFFF_FFFF_FFFF_FFFF -> round_key=64'hFFFF_FFFF_FFFF_FFFF; one next -> round_key=64'h2FFF_FFFF_FFFF_FFFF.
REQ-030 key 0, 31 nexts -> round_idx=32, round_key matches golden K_32 from software model; 32nd next -> valid=0, done=1, round_idx=0; round_key 0 with PRESENT_KS_ZEROIZE_EN, K_32 without.
REQ-031 ACTIVE at round 5, load and next same cycle with key 80'h0 -> round_idx=1, round_key=0, no update applied.
REQ-032 rst_n pulsed low mid-clock at round 10 -> outputs zero before next edge; next ignored afterwards until load.
REQ-033 next held high in DONE and IDLE for 10 cycles -> no output change.
